instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage and IF/ID pipeline register for the LEGv8 datapath, sitting directly upstream of the instruction decode/control unit. It owns the program counter and issues word fetches to instruction memory over a ready-handshake. It buffers one returned instruction when decode is stalled and presents the registered instruction, its PC and the 11-bit opcode field (instr[31:21]) to decode. It accepts branch redirects from the branch-resolution logic and flushes wrong-path work.

## Interface
- ADDR_W, 64, PC and memory address width
- RESET_PC, 0, PC value loaded on reset; bits [1:0] must be 0
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address (equals PC)
- imem_ready  in  1  memory accepts and returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_req && imem_ready
- stall  in  1  decode cannot accept a new instruction this cycle
- branch_taken  in  1  redirect request (pulse)
- branch_target  in  ADDR_W  redirect address; bits [1:0] forced to 0
- if_id_valid  out  1  IF/ID register holds a valid instruction
- if_id_pc  out  ADDR_W  PC of the IF/ID instruction
- if_id_instr  out  32  IF/ID instruction word
- if_id_opcode  out  11  if_id_instr[31:21], feeds decode opcode input

## Operation
- States: FETCH and HOLD.
- In FETCH, imem_req=1 and imem_addr=pc. In HOLD, imem_req=0.
- A fetch completes on a clock edge where imem_req && imem_ready.
- FETCH, fetch completes, stall=0: IF/ID <= {1, pc, imem_rdata}; pc <= pc+4; stay in FETCH.
- FETCH, fetch completes, stall=1: skid <= {pc, imem_rdata}; pc <= pc+4; go to HOLD. IF/ID is unchanged.
- FETCH, no completion, stall=0: if_id_valid <= 0 (bubble).
- FETCH, no completion, stall=1: IF/ID is unchanged.
- HOLD, stall=1: everything holds.
- HOLD, stall=0: IF/ID <= {1, skid}; go to FETCH.
- branch_taken has priority over every rule above:
  - pc <= {branch_target[ADDR_W-1:2], 2'b00}.
  - if_id_valid <= 0 and the skid buffer is discarded.
  - State <= FETCH.
  - Any imem_rdata completing in the same cycle is dropped.
  - branch_taken overrides stall for the flush.
- A request with imem_ready=0 is not committed. The instruction memory must tolerate imem_addr changing or imem_req dropping before ready.
- PC arithmetic is modulo 2^ADDR_W; the increment wraps silently.
- if_id_opcode is a wire slice of if_id_instr; no extra logic.
- The fetch stage never decodes the instruction. Illegal opcodes pass through unchanged.

## Timing
- Reset (rst_n=0, asynchronous): pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_pc=0, if_id_instr=0, skid cleared.
  - Consequently imem_req=1 and imem_addr=RESET_PC during reset and in the first cycle after release.
- Fetch-to-decode latency: 1 edge. Data returned at edge N appears on if_id_* after edge N.
- Zero-wait memory sustains 1 instruction per cycle.
- Redirect penalty: the first target instruction is valid at the earliest 1 cycle after the edge that samples branch_taken.
- Stall release from HOLD: the buffered instruction appears after the first edge with stall=0. A new fetch request is issued in the following cycle.
- Reset asserted mid-fetch or in HOLD aborts immediately to reset values. No partial state survives.

## Test plan
- Reset then zero-wait memory returning 0x8B020020, 0xF8400041, 0xCB030064 -> if_id_pc 0,4,8 on consecutive cycles; if_id_valid=1; if_id_opcode 0x458, 0x7C2, 0x658.
- imem_ready low for 3 cycles on address 0x4 -> imem_addr holds 0x4 and if_id_valid=0 for those cycles; then instr at PC 0x4 is captured.
- stall=1 for 2 cycles while fetch at 0x8 completes -> IF/ID keeps the PC 0x4 instruction and imem_req=0 during HOLD. On release, IF/ID shows PC 0x8 and the next request address is 0xC.
- branch_taken with target 0x103 in the same cycle as a fetch completion at 0x10 -> if_id_valid=0 next cycle and imem_addr=0x100. The 0x10 instruction never appears in IF/ID.
- branch_taken during HOLD with stall=1 -> skid discarded, state FETCH, imem_addr=target, if_id_valid=0.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one fetch -> next imem_addr=0 (wrap). Asserting rst_n=0 mid-stall returns pc to RESET_PC asynchronously.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch port: the request side drives req/addr, and the memory
// answers with ready and rdata in the same cycle.
interface instr_fetch_if #(
  parameter int ADDR_W = 64
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic [31:0]       rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/instr_fetch.sv
// LEGv8 instruction-fetch stage: owns the PC, fetches over a ready handshake,
// buffers one word while decode stalls, and flushes on branch redirects.
module instr_fetch #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_fetch_if.master     imem,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              if_id_valid,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [31:0]       if_id_instr,
  output logic [10:0]       if_id_opcode
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]       skid_instr_q, skid_instr_d;

  logic              fire;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target_aligned;

  assign imem.req       = (state_q == FETCH);
  assign imem.addr      = pc_q;
  assign fire           = imem.req && imem.ready;
  assign pc_plus4       = pc_q + ADDR_W'(4);
  assign target_aligned = branch_target & ~ADDR_W'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      ifpc_q       <= '0;
      instr_q      <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      ifpc_q       <= ifpc_d;
      instr_q      <= instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  // A redirect wins over everything, including a stall and a same-cycle fetch return.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    ifpc_d       = ifpc_q;
    instr_d      = instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (branch_taken) begin
      state_d      = FETCH;
      pc_d         = target_aligned;
      valid_d      = 1'b0;
      skid_pc_d    = '0;
      skid_instr_d = '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (fire) begin
            pc_d = pc_plus4;
            if (stall) begin
              skid_pc_d    = pc_q;
              skid_instr_d = imem.rdata;
              state_d      = HOLD;
            end else begin
              valid_d = 1'b1;
              ifpc_d  = pc_q;
              instr_d = imem.rdata;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            valid_d = 1'b1;
            ifpc_d  = skid_pc_q;
            instr_d = skid_instr_q;
            state_d = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  assign if_id_valid  = valid_q;
  assign if_id_pc     = ifpc_q;
  assign if_id_instr  = instr_q;
  assign if_id_opcode = instr_q[31:21];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a scoreboard queue of expected IF/ID entries is
// drained by a monitor, while control outputs are checked after each cycle.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [10:0] if_id_opcode;

  logic        w_valid;
  logic [63:0] w_pc;
  logic [31:0] w_instr;
  logic [10:0] w_opcode;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [10:0] opcode;
  } exp_t;

  exp_t exp_q[$];
  logic stall_q = 1'b0;

  instr_fetch_if #(.ADDR_W(64)) imem();
  instr_fetch_if #(.ADDR_W(64)) w_imem();

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [63:0] a);
    case (a)
      64'h0:   rom = 32'h8B020020;
      64'h4:   rom = 32'hF8400041;
      64'h8:   rom = 32'hCB030064;
      64'hC:   rom = 32'h91000421;
      64'h10:  rom = 32'hD65F03C0;
      64'h100: rom = 32'hAA0103E2;
      64'h104: rom = 32'hB4000040;
      64'h200: rom = 32'h17FFFFFF;
      default: rom = 32'hD503201F;
    endcase
  endfunction

  assign imem.rdata   = rom(imem.addr);
  assign w_imem.rdata = rom(w_imem.addr);

  instr_fetch #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem.master),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_opcode  (if_id_opcode)
  );

  instr_fetch #(.ADDR_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (w_imem.master),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_valid   (w_valid),
    .if_id_pc      (w_pc),
    .if_id_instr   (w_instr),
    .if_id_opcode  (w_opcode)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic pushExp(input logic [63:0] pc, input logic [31:0] instr, input logic [10:0] opc);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    e.opcode = opc;
    exp_q.push_back(e);
  endtask

  // Sets inputs just after an edge, then advances to 1 time unit past the next edge.
  task automatic applyStimulus(input logic rdy, input logic st, input logic br, input logic [63:0] tgt);
    imem.ready    = rdy;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    @(posedge clk);
    #1;
  endtask

  // IF/ID only loads new content on an edge where decode was not stalled.
  always @(posedge clk) stall_q <= stall;

  always @(negedge clk) begin
    if (rst_n && if_id_valid && !stall_q) begin
      exp_t e;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL sb_unexpected: got pc 0x%0h instr 0x%08h, expected no instruction",
                 if_id_pc, if_id_instr);
      end else begin
        e = exp_q.pop_front();
        if (if_id_pc === e.pc && if_id_instr === e.instr && if_id_opcode === e.opcode)
          pass_cnt++;
        else
          $display("[TB] FAIL sb_ifid: got pc 0x%0h instr 0x%08h opc 0x%0h, expected pc 0x%0h instr 0x%08h opc 0x%0h",
                   if_id_pc, if_id_instr, if_id_opcode, e.pc, e.instr, e.opcode);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    imem.ready = 1'b0;
    w_imem.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req", {63'b0, imem.req}, 64'h1);
    checkOutput("rst_addr", imem.addr, 64'h0);
    checkOutput("rst_valid", {63'b0, if_id_valid}, 64'h0);
    checkOutput("rst_ifpc", if_id_pc, 64'h0);
    checkOutput("rst_instr", {32'b0, if_id_instr}, 64'h0);
    rst_n = 1'b1;
    checkOutput("post_rst_addr", imem.addr, 64'h0);

    $display("[TB] zero-wait stream");
    pushExp(64'h0, 32'h8B020020, 11'h458);
    pushExp(64'h4, 32'hF8400041, 11'h7C2);
    pushExp(64'h8, 32'hCB030064, 11'h658);
    applyStimulus(1, 0, 0, 64'h0);
    checkOutput("stream_addr1", imem.addr, 64'h4);
    applyStimulus(1, 0, 0, 64'h0);
    checkOutput("stream_addr2", imem.addr, 64'h8);
    applyStimulus(1, 0, 0, 64'h0);
    checkOutput("stream_addr3", imem.addr, 64'hC);
    applyStimulus(0, 0, 0, 64'h0);
    checkOutput("bubble_valid", {63'b0, if_id_valid}, 64'h0);

    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_addr", imem.addr, 64'h0);
    checkOutput("async_rst_valid", {63'b0, if_id_valid}, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] wait states, stall, redirects");
    pushExp(64'h0, 32'h8B020020, 11'h458);
    applyStimulus(1, 0, 0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 64'h0);
      checkOutput("wait_addr", imem.addr, 64'h4);
      checkOutput("wait_valid", {63'b0, if_id_valid}, 64'h0);
    end
    pushExp(64'h4, 32'hF8400041, 11'h7C2);
    applyStimulus(1, 0, 0, 64'h0);
    checkOutput("capture4_pc", if_id_pc, 64'h4);

    applyStimulus(1, 1, 0, 64'h0);
    checkOutput("hold1_req", {63'b0, imem.req}, 64'h0);
    checkOutput("hold1_ifpc", if_id_pc, 64'h4);
    applyStimulus(1, 1, 0, 64'h0);
    checkOutput("hold2_req", {63'b0, imem.req}, 64'h0);
    checkOutput("hold2_ifpc", if_id_pc, 64'h4);
    pushExp(64'h8, 32'hCB030064, 11'h658);
    applyStimulus(1, 0, 0, 64'h0);
    checkOutput("release_ifpc", if_id_pc, 64'h8);
    checkOutput("release_req", {63'b0, imem.req}, 64'h1);
    checkOutput("release_addr", imem.addr, 64'hC);

    pushExp(64'hC, 32'h91000421, 11'h488);
    applyStimulus(1, 0, 0, 64'h0);
    checkOutput("fetchC_addr", imem.addr, 64'h10);
    applyStimulus(1, 0, 1, 64'h103);
    checkOutput("br_valid", {63'b0, if_id_valid}, 64'h0);
    checkOutput("br_addr", imem.addr, 64'h100);
    pushExp(64'h100, 32'hAA0103E2, 11'h550);
    applyStimulus(1, 0, 0, 64'h0);
    checkOutput("target_pc", if_id_pc, 64'h100);

    applyStimulus(1, 1, 0, 64'h0);
    checkOutput("hold3_req", {63'b0, imem.req}, 64'h0);
    applyStimulus(0, 1, 1, 64'h200);
    checkOutput("brhold_req", {63'b0, imem.req}, 64'h1);
    checkOutput("brhold_addr", imem.addr, 64'h200);
    checkOutput("brhold_valid", {63'b0, if_id_valid}, 64'h0);
    applyStimulus(0, 0, 0, 64'h0);
    checkOutput("skid_gone_valid", {63'b0, if_id_valid}, 64'h0);

    applyStimulus(1, 1, 0, 64'h0);
    checkOutput("hold4_req", {63'b0, imem.req}, 64'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("midstall_rst_req", {63'b0, imem.req}, 64'h1);
    checkOutput("midstall_rst_addr", imem.addr, 64'h0);
    checkOutput("midstall_rst_valid", {63'b0, if_id_valid}, 64'h0);
    checkOutput("wrap_rst_addr", w_imem.addr, 64'hFFFF_FFFF_FFFF_FFFC);

    $display("[TB] PC wrap");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    w_imem.ready = 1'b1;
    applyStimulus(0, 0, 0, 64'h0);
    w_imem.ready = 1'b0;
    checkOutput("wrap_addr", w_imem.addr, 64'h0);
    checkOutput("wrap_valid", {63'b0, w_valid}, 64'h1);
    checkOutput("wrap_ifpc", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap_opcode", {53'b0, w_opcode}, 64'h6A8);
    checkOutput("main_idle_valid", {63'b0, if_id_valid}, 64'h0);

    @(negedge clk);
    #1;
    checkOutput("sb_leftover", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
